lisnoc_link_vc_mux: RTL and testbench
=====================================

Name: lisnoc_link_vc_mux

Overview:
Shares one physical lisnoc link (flit bus, per-VC one-hot valid, per-VC ready) between `vchannels` independent virtual-channel sources. Each VC source is buffered in a small per-VC FIFO. A round-robin scheduler picks, each cycle, one VC whose FIFO is non-empty and whose downstream ready is high. It sits at a router output port or network-adapter egress, in front of the link.

Parameters:
flit_width, 34, flit width in bits; bits [flit_width-1:flit_width-2] are the flit type, passed through without interpretation.
vchannels, 1, number of virtual channels; 1..8.
fifo_depth, 2, entries per VC FIFO; power of two, at least 2.

Ports:
clk  input  1  clock; all state on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_flit  input  vchannels*flit_width  per-VC source flits; VC v occupies slice [v*flit_width +: flit_width].
in_valid  input  vchannels  per-VC source valid.
in_ready  output  vchannels  per-VC source ready (registered).
out_flit  output  flit_width  link flit.
out_valid  output  vchannels  link valid; one-hot or zero.
out_ready  input  vchannels  per-VC downstream ready.

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, RR pointer = 0, in_ready = 0.
  - out_valid = 0 and out_flit = 0 while in reset.
  - in_ready rises to all-ones on the first edge after release.
  - A reset asserted mid-operation discards all buffered flits immediately. No partial flit is emitted.
- Push, per VC v: occurs when in_valid[v] & in_ready[v] at an edge.
  - in_ready[v] is a register equal to "FIFO v not full next cycle".
  - There is no combinational path from in_valid or out_ready to in_ready.
- Eligibility: eligible[v] = FIFO v non-empty & out_ready[v].
- Grant: the first eligible VC scanning v = ptr, ptr+1, ... modulo vchannels.
  - out_valid = one-hot(grant), or 0 if no VC is eligible.
  - out_flit = head of the granted FIFO, or 0 when nothing is granted.
- Pop: a granted VC pops its head at the edge (valid & ready are both high by construction).
  - ptr <= (grant + 1) mod vchannels on every pop.
  - ptr is unchanged when nothing pops.
- Link convention: out_valid depends combinationally on out_ready. The downstream ready must not depend on valid. Ready is asserted independently of valid, as on every lisnoc link.
- Latency: a flit pushed at edge n can appear on out_valid in the cycle after edge n (1 cycle minimum).
- Throughput: one flit per cycle aggregate. One flit per cycle per VC is sustainable when it is the only eligible VC.
- Simultaneous push and pop on the same VC in one edge: occupancy is unchanged and in_ready stays high.
- Full FIFO: in_ready[v] = 0 from the edge at which it became full. If the FIFO pops on edge k with no push, in_ready[v] returns to 1 after edge k.
- Flits within one VC leave in arrival order. There is no ordering guarantee across VCs.
- Packet boundaries are not tracked: flits of different VCs interleave freely, which VCs permit.
- Per-VC occupancy counters are $clog2(fifo_depth)+1 bits wide, with wrap-around read/write pointers.

Decomposition:
- Package lisnoc_link_pkg holds:
  - flit type constants: PAYLOAD 2'b00, HEADER 2'b01, LAST 2'b10, SINGLE 2'b11;
  - the default flit width;
  - a round-robin helper function (rotate, priority-pick, one-hot) shared with other arbiters.
- Sub-module lisnoc_link_vc_fifo: one-VC synchronous FIFO with registered ready, head-of-queue data, and an empty flag. It is instantiated vchannels times via generate.

Test Plan:
- Reset: hold rst_n=0 with in_valid=all-ones -> in_ready=0, out_valid=0, out_flit=0. One edge after release, in_ready=all-ones. Assert rst_n mid-stream with 2 flits buffered -> out_valid=0 immediately, and no stale flits after release.
- Single VC, vchannels=1: stream 0x1_0000_0001..0x1_0000_0008 with out_ready=1 -> identical order, first flit one cycle after the first push, one flit per cycle.
- Round robin, vchannels=3: all FIFOs pre-filled, out_ready=3'b111 -> out_valid sequence 001, 010, 100, 001, ...
- Round robin skips a blocked VC: out_ready=3'b101 -> 001, 100, 001, 100. VC1 is not granted and its in_ready drops to 0 after 2 pushes.
- Backpressure / full boundary, fifo_depth=2: out_ready[0]=0 with 3 flits offered on VC0 -> 2 accepted, in_ready[0]=0. Raise out_ready[0] -> flit 1 is output and in_ready[0]=1 after that edge. The third flit is then accepted, and all 3 exit in order.
- Concurrent push/pop on a full VC plus random traffic: randomized per-VC valid and out_ready over 10k cycles -> scoreboard confirms no loss, no duplication, per-VC order, out_valid never multi-hot, and no VC starved longer than vchannels grants while eligible.

Source files
------------

// File: rtl/lisnoc_link_vc_mux_pkg.sv
// Shared lisnoc link definitions: flit type codes, default width and the
// round-robin pick used by the link arbiters.
package lisnoc_link_pkg;

  typedef enum logic [1:0] {
    PAYLOAD = 2'b00,
    HEADER  = 2'b01,
    LAST    = 2'b10,
    SINGLE  = 2'b11
  } flit_type_e;

  localparam int FLIT_WIDTH = 34;

  // Arbiters are sized for up to 8 requesters; callers pad their request vector.
  localparam int RR_MAX = 8;
  localparam int RR_IW  = 3;

  // Rotate the request vector to start at ptr, take the first requester and
  // return it one-hot in the original bit positions. n is the live width.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                input logic [RR_IW-1:0]  ptr,
                                                input int                n);
    logic [RR_MAX-1:0] gnt;
    logic              found;
    int                idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = int'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && req[idx[RR_IW-1:0]]) begin
        gnt[idx[RR_IW-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/lisnoc_link_vc_fifo.sv
// Single-VC flit FIFO: registered ready (not full next cycle), head-of-queue
// data and an empty flag for the link scheduler.
module lisnoc_link_vc_fifo
  import lisnoc_link_pkg::*;
#(
  parameter int flit_width = FLIT_WIDTH,
  parameter int fifo_depth = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [flit_width-1:0] in_flit,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  pop,
  output logic [flit_width-1:0] head,
  output logic                  empty
);

  localparam int AW = $clog2(fifo_depth);
  localparam int CW = AW + 1;

  logic [flit_width-1:0] mem [fifo_depth];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic                  push;

  assign push      = in_valid & in_ready;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign head      = mem[rd_ptr];
  assign empty     = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      // Looks at next occupancy so a same-edge push+pop on a full FIFO keeps ready.
      in_ready <= (count_nxt != CW'(fifo_depth));
    end
  end

  // Storage needs no reset: head is only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_flit;
  end

endmodule

// File: rtl/lisnoc_link_vc_mux.sv
// Muxes vchannels buffered VC sources onto one lisnoc link with a
// round-robin pick among VCs that hold a flit and see downstream ready.
module lisnoc_link_vc_mux
  import lisnoc_link_pkg::*;
#(
  parameter int flit_width = FLIT_WIDTH,
  parameter int vchannels  = 1,
  parameter int fifo_depth = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [vchannels*flit_width-1:0] in_flit,
  input  logic [vchannels-1:0]            in_valid,
  output logic [vchannels-1:0]            in_ready,
  output logic [flit_width-1:0]           out_flit,
  output logic [vchannels-1:0]            out_valid,
  input  logic [vchannels-1:0]            out_ready
);

  logic [vchannels-1:0][flit_width-1:0] head;
  logic [vchannels-1:0]                 empty, grant;
  logic [RR_MAX-1:0]                    req, gnt_all;
  logic [RR_IW-1:0]                     ptr, ptr_nxt;

  for (genvar v = 0; v < vchannels; v++) begin : g_vc
    lisnoc_link_vc_fifo #(
      .flit_width(flit_width),
      .fifo_depth(fifo_depth)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_flit (in_flit[v*flit_width +: flit_width]),
      .in_valid(in_valid[v]),
      .in_ready(in_ready[v]),
      .pop     (grant[v]),
      .head    (head[v]),
      .empty   (empty[v])
    );
  end

  always_comb begin
    req                = '0;
    req[vchannels-1:0] = ~empty & out_ready;
  end

  assign gnt_all   = rr_pick(req, ptr, vchannels);
  assign grant     = gnt_all[vchannels-1:0];
  assign out_valid = grant;

  if (vchannels < RR_MAX) begin : g_pad
    logic unused_gnt;
    assign unused_gnt = ^gnt_all[RR_MAX-1:vchannels];
  end

  always_comb begin
    out_flit = '0;
    ptr_nxt  = ptr;
    for (int v = 0; v < vchannels; v++) begin
      if (grant[v]) begin
        out_flit = head[v];
        ptr_nxt  = RR_IW'((v + 1) % vchannels);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
  end

endmodule

// File: tb/tb_lisnoc_link_vc_mux.sv
// Randomized scoreboard bench for lisnoc_link_vc_mux: per-VC expected queues
// fed on accepted pushes, checked against every link cycle.
module tb_lisnoc_link_vc_mux;

  localparam int FW    = 34;
  localparam int VC    = 3;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [VC*FW-1:0] in_flit;
  logic [VC-1:0]    in_valid, in_ready, out_valid, out_ready;
  logic [FW-1:0]    out_flit;

  lisnoc_link_vc_mux #(.flit_width(FW), .vchannels(VC), .fifo_depth(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_flit  (in_flit),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_flit (out_flit),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [FW-1:0] q [VC][$];
  int            ptr_m;
  bit            armed;
  int            wait_cnt [VC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a VC is eligible when its queue holds a flit and its ready is
  // high; the winner is the first eligible VC counting up from ptr_m.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready",  64'(in_ready),  64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_flit",  64'(out_flit),  64'(0));
      for (int v = 0; v < VC; v++) begin
        q[v].delete();
        wait_cnt[v] = 0;
      end
      ptr_m = 0;
      armed = 1'b0;
    end else begin
      int            g;
      logic [VC-1:0] elig, exp_rdy;
      g = -1;
      for (int v = 0; v < VC; v++) begin
        elig[v]    = (q[v].size() > 0) && out_ready[v];
        exp_rdy[v] = armed && (q[v].size() < DEPTH);
      end
      for (int i = 0; i < VC; i++) begin
        int v;
        v = (ptr_m + i) % VC;
        if (g < 0 && elig[v]) g = v;
      end
      chk("out_valid", 64'(out_valid), (g < 0) ? 64'(0) : (64'(1) << g));
      chk("out_flit",  64'(out_flit),  (g < 0) ? 64'(0) : 64'(q[g][0]));
      chk("in_ready",  64'(in_ready),  64'(exp_rdy));
      chk("onehot",    64'($countones(out_valid) <= 1), 64'(1));
      for (int v = 0; v < VC; v++) begin
        if (!elig[v])    wait_cnt[v] = 0;
        else if (v != g) wait_cnt[v]++;
      end
      if (g >= 0) begin
        chk("starvation", 64'(wait_cnt[g] < VC), 64'(1));
        wait_cnt[g] = 0;
        void'(q[g].pop_front());
        ptr_m = (g + 1) % VC;
      end
      for (int v = 0; v < VC; v++)
        if (in_valid[v] && in_ready[v]) q[v].push_back(in_flit[v*FW +: FW]);
      armed = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [VC-1:0] v_during);
    in_valid  = v_during;
    out_ready = '1;
    rst_n     = 1'b0;
    repeat (3) cyc();
    chk("hold_in_ready",  64'(in_ready),  64'(0));
    chk("hold_out_valid", 64'(out_valid), 64'(0));
    chk("hold_out_flit",  64'(out_flit),  64'(0));
    in_valid = '0;
    rst_n    = 1'b1;
    cyc();
    chk("release_in_ready", 64'(in_ready), 64'({VC{1'b1}}));
  endtask

  task automatic send(input int v, input logic [FW-1:0] f);
    bit acc;
    int guard;
    guard = 0;
    in_valid[v]          = 1'b1;
    in_flit[v*FW +: FW]  = f;
    do begin
      acc = in_ready[v];
      cyc();
      guard++;
    end while (!acc && guard < 100);
    chk("send_accept", 64'(acc), 64'(1));
    in_valid[v] = 1'b0;
  endtask

  task automatic drain(input int budget);
    int left;
    in_valid  = '0;
    out_ready = '1;
    for (int c = 0; c < budget; c++) begin
      left = 0;
      for (int v = 0; v < VC; v++) left += q[v].size();
      if (left == 0) break;
      cyc();
    end
    left = 0;
    for (int v = 0; v < VC; v++) left += q[v].size();
    chk("drain_empty", 64'(left), 64'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_flit   = '0;
    out_ready = '0;

    do_reset('1);

    // single VC stream, one flit per cycle
    out_ready = '1;
    for (int k = 1; k <= 8; k++) send(0, 34'h1_0000_0000 + FW'(k));
    drain(20);

    // round robin with every FIFO pre-filled
    do_reset('0);
    out_ready = '0;
    in_valid  = '1;
    for (int c = 0; c < 14; c++) begin
      if (c == 2) out_ready = 3'b111;
      for (int v = 0; v < VC; v++) in_flit[v*FW +: FW] = FW'((v << 16) | c);
      cyc();
    end
    drain(20);

    // VC1 blocked downstream: skipped, fills up, drops its ready
    do_reset('0);
    out_ready = 3'b101;
    in_valid  = '1;
    for (int c = 0; c < 12; c++) begin
      for (int v = 0; v < VC; v++) in_flit[v*FW +: FW] = FW'((v << 20) | (c + 100));
      cyc();
    end
    chk("vc1_full_ready", 64'(in_ready[1]), 64'(0));
    drain(20);

    // full-FIFO boundary on VC0
    do_reset('0);
    out_ready = '0;
    in_valid[0] = 1'b1;
    in_flit[0 +: FW] = 34'h2_AAAA_0001; cyc();
    in_flit[0 +: FW] = 34'h2_AAAA_0002; cyc();
    chk("full_ready_low", 64'(in_ready[0]), 64'(0));
    in_flit[0 +: FW] = 34'h2_AAAA_0003; cyc(); cyc();
    chk("full_ready_hold", 64'(in_ready[0]), 64'(0));
    out_ready[0] = 1'b1;
    cyc();
    chk("ready_after_pop", 64'(in_ready[0]), 64'(1));
    cyc();
    drain(20);

    // reset mid-stream with two flits buffered on VC1
    do_reset('0);
    out_ready = '0;
    in_valid[1] = 1'b1;
    in_flit[FW +: FW] = 34'h3_0000_0001; cyc();
    in_flit[FW +: FW] = 34'h3_0000_0002; cyc();
    in_valid  = '0;
    out_ready = '1;
    #1;
    chk("pre_reset_valid", 64'(out_valid), 64'(3'b010));
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", 64'(out_valid), 64'(0));
    chk("mid_reset_flit",  64'(out_flit),  64'(0));
    do_reset('0);
    repeat (4) cyc();

    // randomized traffic
    do_reset('0);
    for (int c = 0; c < 10000; c++) begin
      logic [VC-1:0] acc;
      acc = in_valid & in_ready;
      cyc();
      for (int v = 0; v < VC; v++) begin
        if (acc[v] || !in_valid[v]) begin
          logic [63:0] r;
          r = {$urandom, $urandom};
          in_valid[v]         = ($urandom_range(0, 3) != 0);
          in_flit[v*FW +: FW] = r[FW-1:0];
        end
      end
      out_ready = VC'($urandom);
    end
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
